// File: rtl/audio_clk_pkg.sv
// audio_clk_pkg
// Purpose: shared types and widths for the serial-audio clock generator.
//   - mode_e  : frame format (I2S 50% LRCLK or TDM one-BCLK frame pulse)
//   - state_t : run-control state encoding (IDLE, RUN, STOP)
//   - BIT_IDX_W / SLOT_IDX_W : widths of the bit-in-slot and slot indices
package audio_clk_pkg;

  localparam int BIT_IDX_W  = 5;
  localparam int SLOT_IDX_W = 4;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_TDM = 1'b1
  } mode_e;

  // Plain encoded constants so the state register stays a simple vector.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t STOP = 2'd2;

endpackage

// File: rtl/audio_lock_qualifier.sv
// audio_lock_qualifier
// Purpose: brings the asynchronous PLL lock flag into the refclk domain and
//   only declares the clock usable after it has stayed locked for LOCK_HOLD
//   consecutive synchronised cycles.
// Ports:
//   refclk     in  system clock, rising edge
//   rst_n      in  synchronous active-low reset
//   pll_locked in  raw PLL lock (asynchronous)
//   clk_ready  out lock qualified (registered)
//   loss_evt   out high for the single cycle before clk_ready drops from 1 to 0
module audio_lock_qualifier
  import audio_clk_pkg::*;
#(
  parameter int LOCK_HOLD = 1024
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic clk_ready,
  output logic loss_evt
);

  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LOCK_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              sync_q1;
  logic              locked_s;
  logic [HOLD_W-1:0] hold_cnt;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
    end
  end

  // Hold counter saturates at LOCK_HOLD; clk_ready is set on the same edge the
  // counter reaches LOCK_HOLD and dropped as soon as the synchronised lock goes away.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      clk_ready <= 1'b0;
    end else if (!locked_s) begin
      hold_cnt  <= '0;
      clk_ready <= 1'b0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt  <= hold_cnt + HOLD_ONE;
      clk_ready <= (hold_cnt == HOLD_LAST);
    end
  end

  // Flags the cycle in which clk_ready is about to fall, so downstream logic can
  // go idle on the very edge that clears clk_ready.
  assign loss_evt = clk_ready & ~locked_s;

endmodule

// File: rtl/audio_frame_clock_gen.sv
// audio_frame_clock_gen
// Purpose: bit clock, frame clock and per-bit/slot strobes for the codec
//   serial-audio path, derived from refclk and gated by PLL lock qualification.
// Ports:
//   refclk, rst_n          clock (rising edge) and synchronous active-low reset
//   pll_locked             raw PLL lock flag (asynchronous)
//   enable                 run request
//   mode                   0 = I2S (50% LRCLK), 1 = TDM (one-BCLK frame pulse)
//   clk_ready              lock qualified
//   running                frame clocks active (RUN or STOP)
//   bclk_out, lrclk_out    bit clock and LRCLK / frame sync
//   bclk_rise_stb/fall_stb one-cycle pulses at div_cnt = BCLK_DIV/2 and 0
//   frame_start            one-cycle pulse at bit 0 of slot 0
//   bit_idx, slot_idx      current bit in slot (0 = MSB) and current slot
//   lock_loss_count        saturating count of lock losses
// Build option: AUDIO_CLK_LOSS_COUNT_EN - when defined the lock-loss counter is
//   built; when undefined lock_loss_count is tied to zero.
module audio_frame_clock_gen
  import audio_clk_pkg::*;
#(
  parameter int BCLK_DIV  = 32,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2,
  parameter int LOCK_HOLD = 1024
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  enable,
  input  logic                  mode,
  output logic                  clk_ready,
  output logic                  running,
  output logic                  bclk_out,
  output logic                  lrclk_out,
  output logic                  bclk_rise_stb,
  output logic                  bclk_fall_stb,
  output logic                  frame_start,
  output logic [BIT_IDX_W-1:0]  bit_idx,
  output logic [SLOT_IDX_W-1:0] slot_idx,
  output logic [7:0]            lock_loss_count
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0]      DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(SLOT_BITS - 1);
  localparam logic [BIT_IDX_W-1:0]  BIT_ONE   = BIT_IDX_W'(1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_LAST = SLOT_IDX_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_HALF = SLOT_IDX_W'(NUM_SLOTS / 2);
  localparam logic [SLOT_IDX_W-1:0] SLOT_ONE  = SLOT_IDX_W'(1);

  logic                  loss_evt;
  logic                  ready_ok;
  logic                  frame_end;
  state_t                state;
  state_t                state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic [BIT_IDX_W-1:0]  bit_nxt;
  logic [SLOT_IDX_W-1:0] slot_nxt;
  mode_e                 mode_q;
  mode_e                 mode_nxt;
  logic                  run_nxt;
  logic                  fs_nxt;
  logic                  lr_nxt;

  audio_lock_qualifier #(
    .LOCK_HOLD (LOCK_HOLD)
  ) u_lock (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .clk_ready  (clk_ready),
    .loss_evt   (loss_evt)
  );

  // Next-state, counter and output decode. Outputs are registered from the
  // next counter values so they line up with bit_idx/slot_idx in the same cycle.
  always_comb begin
    ready_ok  = clk_ready & ~loss_evt;
    frame_end = (div_cnt == DIV_LAST) && (bit_idx == BIT_LAST) && (slot_idx == SLOT_LAST);
    state_nxt = IDLE;
    div_nxt   = '0;
    bit_nxt   = '0;
    slot_nxt  = '0;
    lr_nxt    = 1'b0;

    case (state)
      IDLE:      state_nxt = (ready_ok && enable) ? RUN : IDLE;
      RUN, STOP: begin
        if (!ready_ok)     state_nxt = IDLE;
        else if (!enable)  state_nxt = frame_end ? IDLE : STOP;
        else               state_nxt = RUN;
      end
      default:   state_nxt = IDLE;
    endcase

    run_nxt = (state_nxt != IDLE);

    // Counters only advance while staying active; entering RUN from IDLE
    // leaves them at zero so the first cycle is bit 0 of slot 0.
    if (state != IDLE && run_nxt) begin
      if (div_cnt == DIV_LAST) begin
        if (bit_idx == BIT_LAST) begin
          slot_nxt = (slot_idx == SLOT_LAST) ? '0 : slot_idx + SLOT_ONE;
        end else begin
          bit_nxt  = bit_idx + BIT_ONE;
          slot_nxt = slot_idx;
        end
      end else begin
        div_nxt  = div_cnt + DIV_ONE;
        bit_nxt  = bit_idx;
        slot_nxt = slot_idx;
      end
    end

    fs_nxt   = run_nxt && (div_nxt == '0) && (bit_nxt == '0) && (slot_nxt == '0);
    mode_nxt = fs_nxt ? mode_e'(mode) : mode_q;

    if (run_nxt) begin
      if (mode_nxt == MODE_TDM) lr_nxt = (bit_nxt == '0) && (slot_nxt == '0);
      else                      lr_nxt = (slot_nxt >= SLOT_HALF);
    end
  end

  // Run-control state, counters, latched frame mode and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_idx       <= '0;
      slot_idx      <= '0;
      mode_q        <= MODE_I2S;
      running       <= 1'b0;
      bclk_out      <= 1'b0;
      lrclk_out     <= 1'b0;
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      bit_idx       <= bit_nxt;
      slot_idx      <= slot_nxt;
      mode_q        <= mode_nxt;
      running       <= run_nxt;
      bclk_out      <= run_nxt && (div_nxt >= DIV_HALF);
      lrclk_out     <= lr_nxt;
      bclk_rise_stb <= run_nxt && (div_nxt == DIV_HALF);
      bclk_fall_stb <= run_nxt && (div_nxt == '0);
      frame_start   <= fs_nxt;
    end
  end

`ifdef AUDIO_CLK_LOSS_COUNT_EN
  // Saturating lock-loss counter; only rst_n clears it.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_loss_count <= '0;
    end else if (loss_evt && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_audio_frame_clock_gen.sv
// tb_audio_frame_clock_gen
// Purpose: self-checking bench for audio_frame_clock_gen with a small
//   configuration (BCLK_DIV=4, SLOT_BITS=4, NUM_SLOTS=4, LOCK_HOLD=16).
//   Expected clock/strobe/index values come from a position-in-frame model.
module tb_audio_frame_clock_gen;

  localparam int D     = 4;
  localparam int SB    = 4;
  localparam int NS    = 4;
  localparam int LH    = 16;
  localparam int FRAME = D * SB * NS;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       enable;
  logic       mode;
  logic       clk_ready;
  logic       running;
  logic       bclk_out;
  logic       lrclk_out;
  logic       bclk_rise_stb;
  logic       bclk_fall_stb;
  logic       frame_start;
  logic [4:0] bit_idx;
  logic [3:0] slot_idx;
  logic [7:0] lock_loss_count;

  int   checks = 0;
  int   errors = 0;
  int   run_k;
  logic frame_mode;
  int   exp_losses;

  audio_frame_clock_gen #(
    .BCLK_DIV  (D),
    .SLOT_BITS (SB),
    .NUM_SLOTS (NS),
    .LOCK_HOLD (LH)
  ) dut (
    .refclk          (refclk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .enable          (enable),
    .mode            (mode),
    .clk_ready       (clk_ready),
    .running         (running),
    .bclk_out        (bclk_out),
    .lrclk_out       (lrclk_out),
    .bclk_rise_stb   (bclk_rise_stb),
    .bclk_fall_stb   (bclk_fall_stb),
    .frame_start     (frame_start),
    .bit_idx         (bit_idx),
    .slot_idx        (slot_idx),
    .lock_loss_count (lock_loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected {bclk, lrclk, rise, fall, frame_start, bit[4:0], slot[3:0]} for the
  // k-th cycle after the first frame_start, given the frame's latched mode.
  function automatic logic [13:0] model_vec(input int k, input logic m);
    int dv;
    int bt;
    int sl;
    logic [13:0] v;
    dv = k % D;
    bt = (k / D) % SB;
    sl = (k / (D * SB)) % NS;
    v[13]  = (dv >= D / 2);
    v[12]  = m ? ((bt == 0) && (sl == 0)) : (sl >= NS / 2);
    v[11]  = (dv == D / 2);
    v[10]  = (dv == 0);
    v[9]   = ((k % FRAME) == 0);
    v[8:4] = 5'(bt);
    v[3:0] = 4'(sl);
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bclk_out, lrclk_out, bclk_rise_stb, bclk_fall_stb, frame_start, bit_idx, slot_idx};
  endfunction

  function automatic logic [7:0] exp_count();
`ifdef AUDIO_CLK_LOSS_COUNT_EN
    return (exp_losses > 255) ? 8'd255 : 8'(exp_losses);
`else
    return 8'd0;
`endif
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({clk_ready, running, dut_vec(), lock_loss_count} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected 000000", {clk_ready, running, dut_vec(), lock_loss_count});
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({clk_ready, running, dut_vec()} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle got %h expected 0000", {clk_ready, running, dut_vec()});
    end
  endtask

  task automatic test_lock_qualify();
    int d;
    d = $urandom_range(3, 12);
    enable = 1'b1;
    mode   = 1'b0;
    repeat (d) step();
    pll_locked = 1'b1;
    for (int i = 1; i <= LH + 3; i++) begin
      step();
      checks++;
      if (clk_ready !== ((i >= LH + 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL lock_qualify cycle %0d clk_ready got %b expected %b", i, clk_ready, (i >= LH + 2));
      end
      checks++;
      if (i == LH + 3) begin
        if (frame_start !== 1'b1 || running !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_frame_start got fs=%b run=%b expected fs=1 run=1", frame_start, running);
        end
      end else if (running !== 1'b0) begin
        errors++;
        $display("[TB] FAIL early_running cycle %0d got %b expected 0", i, running);
      end
    end
    run_k      = 0;
    frame_mode = mode;
  endtask

  task automatic test_i2s_frame();
    int lr_hi;
    int bclk_hi;
    int rises;
    int starts;
    lr_hi = 0; bclk_hi = 0; rises = 0; starts = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
      lr_hi   += int'(lrclk_out);
      bclk_hi += int'(bclk_out);
      rises   += int'(bclk_rise_stb);
      starts  += int'(frame_start);
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL i2s_frame k=%0d got %h run=%b expected %h run=1", run_k, dut_vec(), running, model_vec(run_k, frame_mode));
      end
    end
    checks++;
    if (lr_hi != FRAME) begin
      errors++;
      $display("[TB] FAIL i2s_lrclk_duty high cycles got %0d expected %0d", lr_hi, FRAME);
    end
    checks++;
    if (bclk_hi != FRAME || rises != 2 * FRAME / D) begin
      errors++;
      $display("[TB] FAIL bclk_duty got high=%0d rises=%0d expected high=%0d rises=%0d", bclk_hi, rises, FRAME, 2 * FRAME / D);
    end
    checks++;
    if (starts != 2) begin
      errors++;
      $display("[TB] FAIL frame_period starts got %0d expected 2", starts);
    end
  endtask

  task automatic test_tdm_switch();
    int s;
    int lr_hi;
    s = $urandom_range(5, 50);
    for (int n = 0; n < FRAME && (run_k % FRAME) != s; n++) begin
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode)) begin
        errors++;
        $display("[TB] FAIL pre_switch k=%0d got %h expected %h", run_k, dut_vec(), model_vec(run_k, frame_mode));
      end
    end
    mode = 1'b1;
    for (int n = 0; n < FRAME && (run_k % FRAME) != 0; n++) begin
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode)) begin
        errors++;
        $display("[TB] FAIL mode_midframe k=%0d got %h expected %h", run_k, dut_vec(), model_vec(run_k, frame_mode));
      end
    end
    lr_hi = int'(lrclk_out);
    for (int n = 1; n < 2 * FRAME; n++) begin
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
      lr_hi += int'(lrclk_out);
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode)) begin
        errors++;
        $display("[TB] FAIL tdm_frame k=%0d got %h expected %h", run_k, dut_vec(), model_vec(run_k, frame_mode));
      end
    end
    checks++;
    if (lr_hi != 2 * D) begin
      errors++;
      $display("[TB] FAIL tdm_pulse_width high cycles got %0d expected %0d", lr_hi, 2 * D);
    end
  endtask

  task automatic test_stop();
    for (int n = 0; n < FRAME && (run_k % FRAME) != 36; n++) begin
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
    end
    enable = 1'b0;
    for (int n = 0; n < FRAME && (run_k % FRAME) != FRAME - 1; n++) begin
      step();
      run_k++;
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stop_drain k=%0d got %h run=%b expected %h run=1", run_k, dut_vec(), running, model_vec(run_k, frame_mode));
      end
    end
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if ({running, dut_vec()} !== 15'h0 || clk_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stop_idle cycle %0d got run=%b out=%h ready=%b expected run=0 out=0000 ready=1", n, running, dut_vec(), clk_ready);
      end
    end
  endtask

  task automatic test_stop_reenable();
    int r;
    int q;
    enable = 1'b1;
    step();
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_entry got fs=%b run=%b expected fs=1 run=1", frame_start, running);
    end
    run_k      = 0;
    frame_mode = mode;
    r = $urandom_range(5, 30);
    q = $urandom_range(1, 20);
    for (int n = 0; n < r + q + 80; n++) begin
      if (n == r) enable = 1'b0;
      if (n == r + q) enable = 1'b1;
      step();
      run_k++;
      if (run_k % FRAME == 0) frame_mode = mode;
      checks++;
      if (dut_vec() !== model_vec(run_k, frame_mode) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stop_reenable k=%0d got %h run=%b expected %h run=1", run_k, dut_vec(), running, model_vec(run_k, frame_mode));
      end
      if (n >= r + q) mode = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_lock_loss();
    int s;
    for (int p = 0; p < 3; p++) begin
      s = $urandom_range(5, 40);
      for (int n = 0; n < s + 2; n++) begin
        if (n == s) pll_locked = 1'b0;
        step();
        run_k++;
        if (run_k % FRAME == 0) frame_mode = mode;
        checks++;
        if (dut_vec() !== model_vec(run_k, frame_mode) || running !== 1'b1) begin
          errors++;
          $display("[TB] FAIL pre_loss k=%0d got %h run=%b expected %h run=1", run_k, dut_vec(), running, model_vec(run_k, frame_mode));
        end
      end
      step();
      exp_losses++;
      checks++;
      if ({clk_ready, running, dut_vec()} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL loss_idle pulse %0d got %h expected 0000", p, {clk_ready, running, dut_vec()});
      end
      step();
      step();
      pll_locked = 1'b1;
      for (int i = 1; i <= LH + 3; i++) begin
        step();
        checks++;
        if (clk_ready !== ((i >= LH + 2) ? 1'b1 : 1'b0) || running !== ((i == LH + 3) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("[TB] FAIL loss_restart pulse %0d cycle %0d got ready=%b run=%b", p, i, clk_ready, running);
        end
      end
      checks++;
      if (frame_start !== 1'b1) begin
        errors++;
        $display("[TB] FAIL loss_restart_fs pulse %0d got %b expected 1", p, frame_start);
      end
      run_k      = 0;
      frame_mode = mode;
    end
    checks++;
    if (lock_loss_count !== exp_count()) begin
      errors++;
      $display("[TB] FAIL loss_count got %0d expected %0d", lock_loss_count, exp_count());
    end
  endtask

  task automatic test_loss_saturate();
    bit got;
    enable = 1'b0;
    for (int n = 0; n < 300; n++) begin
      pll_locked = 1'b0;
      repeat (3) step();
      exp_losses++;
      if (exp_losses == 255) begin
        checks++;
        if (lock_loss_count !== exp_count()) begin
          errors++;
          $display("[TB] FAIL loss_count_255 got %0d expected %0d", lock_loss_count, exp_count());
        end
      end
      pll_locked = 1'b1;
      got = 1'b0;
      for (int j = 0; j < 40 && !got; j++) begin
        step();
        if (clk_ready === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL relock_timeout loss %0d got ready=%b expected 1", n, clk_ready);
        break;
      end
    end
    checks++;
    if (lock_loss_count !== exp_count()) begin
      errors++;
      $display("[TB] FAIL loss_count_saturate got %0d expected %0d", lock_loss_count, exp_count());
    end
  endtask

  task automatic test_reset_midframe();
    int r;
    enable = 1'b1;
    step();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_start got %b expected 1", frame_start);
    end
    r = $urandom_range(10, 50);
    repeat (r) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({clk_ready, running, dut_vec(), lock_loss_count} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL midframe_reset got %h expected 000000", {clk_ready, running, dut_vec(), lock_loss_count});
    end
    rst_n      = 1'b1;
    exp_losses = 0;
    for (int i = 1; i <= LH + 3; i++) begin
      step();
      checks++;
      if (clk_ready !== ((i >= LH + 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL reset_relock cycle %0d got %b expected %b", i, clk_ready, (i >= LH + 2));
      end
    end
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1 || lock_loss_count !== exp_count()) begin
      errors++;
      $display("[TB] FAIL reset_restart got fs=%b run=%b cnt=%0d expected fs=1 run=1 cnt=0", frame_start, running, lock_loss_count);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    enable     = 1'b0;
    mode       = 1'b0;
    run_k      = 0;
    frame_mode = 1'b0;
    exp_losses = 0;
    $display("[TB] starting audio_frame_clock_gen bench");
    test_reset();
    test_lock_qualify();
    test_i2s_frame();
    test_tdm_switch();
    test_stop();
    test_stop_reenable();
    test_lock_loss();
    test_loss_saturate();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_clock_gen.md
# audio_frame_clock_gen

Generates the serial-audio bit clock, frame clock and per-bit/slot strobes for the AD1939 codec path from the PLL-derived system clock, qualified by the PLL lock indication. Sits directly downstream of the MCLK-derived system-clock PLL and feeds the serialiser/deserialiser. Generalises a fixed 2-channel I2S clocking scheme to parametrised divide ratio, slot width, slot count and I2S/TDM framing, with lock-loss handling.

## Interface
- BCLK_DIV, 32: system clocks per bit-clock period; even, ≥4 (98.304 MHz / 32 = 3.072 MHz)
- SLOT_BITS, 32: bit clocks per slot, 8..32
- NUM_SLOTS, 2: slots per frame, even, 2..16
- LOCK_HOLD, 1024: consecutive synchronised-locked cycles required before ready, ≥2

- refclk  in  1  system clock (PLL outclk); all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- pll_locked  in  1  PLL lock, asynchronous; 2-FF synchronised internally
- enable  in  1  run request
- mode  in  1  0 = I2S (50% LRCLK), 1 = TDM (one-BCLK frame pulse)
- clk_ready  out  1  lock qualified
- running  out  1  frame clocks active
- bclk_out  out  1  bit clock
- lrclk_out  out  1  LRCLK / frame sync
- bclk_rise_stb  out  1  one-cycle pulse, cycle bclk_out goes high
- bclk_fall_stb  out  1  one-cycle pulse, cycle bclk_out goes low
- frame_start  out  1  one-cycle pulse at bit 0, slot 0
- bit_idx  out  5  current bit in slot, 0 = MSB
- slot_idx  out  4  current slot
- lock_loss_count  out  8  saturating count of lock losses

## Operation
- Reset: all outputs 0, all counters 0, state IDLE.
- Lock qualifier: locked_s = synchronised pll_locked. Hold counter increments while locked_s = 1, clears when 0; clk_ready = 1 once the counter reaches LOCK_HOLD, stays 1 until locked_s = 0.
- States: IDLE → RUN when clk_ready & enable; RUN → STOP when enable = 0; STOP → IDLE at the end of the current frame (last div cycle of bit SLOT_BITS-1 of slot NUM_SLOTS-1); RUN/STOP → IDLE immediately when clk_ready falls.
- running = 1 in RUN and STOP.
- div_cnt 0..BCLK_DIV-1, wraps; bclk_out = (div_cnt ≥ BCLK_DIV/2). bit_idx increments on div wrap, wraps at SLOT_BITS-1 and increments slot_idx, which wraps at NUM_SLOTS-1.
- mode is latched on entry to RUN and at every frame_start; mid-frame changes are ignored.
- I2S: lrclk_out = 0 for slot_idx < NUM_SLOTS/2, 1 otherwise; transitions coincide with bclk falling edge at bit 0 (serialiser applies the one-bit I2S delay).
- TDM: lrclk_out = 1 exactly during bit 0 of slot 0, else 0.
- IDLE: bclk_out, lrclk_out, strobes 0; counters held at 0. Entry to RUN starts at div_cnt = 0, bit 0, slot 0 with frame_start.
- Lock loss (clk_ready 1→0): lock_loss_count += 1, saturating at 255; counters cleared, outputs idle in the following cycle. Only rst_n clears the count.
- enable reasserted during STOP: return to RUN, no frame break.

## Timing
- pll_locked rise → clk_ready: 2 + LOCK_HOLD cycles. pll_locked fall → clk_ready low: 3 cycles.
- clk_ready & enable → running and first frame_start: 1 cycle after the enabling edge.
- All outputs registered; strobes exactly one refclk cycle wide.
- bclk_fall_stb at div_cnt = 0, bclk_rise_stb at div_cnt = BCLK_DIV/2.
- Frame length: BCLK_DIV × SLOT_BITS × NUM_SLOTS cycles.

## Configuration
- AUDIO_CLK_LOSS_COUNT_EN defined: lock_loss_count behaves as specified.
- Undefined: counter not built, lock_loss_count tied to 0; all other behaviour identical.

## Structure
- Package audio_clk_pkg: mode enum (MODE_I2S, MODE_TDM), state enum (IDLE, RUN, STOP), bit_idx/slot_idx widths.
- Sub-module audio_lock_qualifier: synchroniser, hold counter, clk_ready, loss event pulse.

## Test plan
- Bench params BCLK_DIV=4, SLOT_BITS=4, NUM_SLOTS=4, LOCK_HOLD=16.
- pll_locked high at cycle 10, enable high → clk_ready at cycle 28, frame_start one cycle after; frame_start period 64 cycles.
- mode=0 → lrclk_out low 32 cycles, high 32 cycles; bclk period 4, duty 50%; rise/fall strobes at div 2/0.
- mode=1 → lrclk_out high 4 cycles per 64; mode toggled mid-frame takes effect only at next frame_start.
- enable dropped at bit 1 slot 2 → running stays 1 until frame end, then 0 with all outputs 0.
- pll_locked pulsed low 5 cycles mid-frame, three times → outputs idle within 3 cycles, restart after 18 cycles; lock_loss_count = 3 (0 without macro); 300 losses → 255.
- rst_n low mid-frame → every output 0 next cycle, count cleared.
